// File: rtl/raster_pkg.sv
// Shared raster constants and types for the pixel write-back path.
package raster_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FB_ADDR_W = 19;
    localparam int COLOR_W   = 3;
    localparam int PX_W      = 10 + 10 + COLOR_W;

    typedef struct packed {
        logic [9:0]         x;
        logic [9:0]         y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } wr_state_t;

endpackage

// File: rtl/px_fifo.sv
// Small synchronous pixel FIFO; head word is visible on dout while not empty.
module px_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = raster_pkg::PX_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
    end

    // Storage write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == (AW+1)'(0));
    assign count = count_r;

endmodule

// File: rtl/px_writer.sv
// Pixel write-back stage: clips and queues pixels, converts them to linear
// frame-buffer addresses, and runs full-screen clears. The frame-buffer port
// is a registered one-entry slot that counts toward FIFO occupancy.
module px_writer #(
    parameter int H_RES      = raster_pkg::H_RES,
    parameter int V_RES      = raster_pkg::V_RES,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = raster_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        Xn,
    input  logic [9:0]        Yn,
    input  logic [2:0]        Px_Color,
    input  logic              px_valid,
    output logic              frame_ready,
    input  logic              clear_req,
    input  logic [2:0]        clear_color,
    output logic              clear_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_wdata,
    output logic              fb_we,
    input  logic              fb_busy,
    output logic [15:0]       dropped
);

    import raster_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [10:0]       X_LIM     = 11'(H_RES);
    localparam logic [10:0]       Y_LIM     = 11'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CW:0]       RDY_LIM   = (CW+1)'(FIFO_DEPTH - 2);

    // Linear address; 640 uses the shift-add form Y*512 + Y*128 + X.
    function automatic logic [ADDR_W-1:0] px_addr(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] xe;
        logic [31:0] ye;
        logic [31:0] t;
        xe = {22'd0, x};
        ye = {22'd0, y};
        if (H_RES == 640) begin
            t = (ye << 9) + (ye << 7) + xe;
        end else begin
            t = ye * 32'(H_RES) + xe;
        end
        return t[ADDR_W-1:0];
    endfunction

    wr_state_t         st_r, st_d;
    logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_d;
    logic [2:0]        clr_color_r, clr_color_d;
    logic              frame_ready_r, frame_ready_d;
    logic              clear_done_r, clear_done_d;
    logic [15:0]       dropped_r, dropped_d;
    logic              fb_we_r, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_r, fb_addr_d;
    logic [2:0]        fb_wdata_r, fb_wdata_d;

    pixel_t            in_px_s, head_px_s, sel_px_s;
    logic [PX_W-1:0]   fifo_dout_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [CW-1:0]     fifo_count_s, fifo_cnt_nx_s;
    logic [CW:0]       occ_nx_s;
    logic              accept_s, clip_s, push_in_s, bypass_s;
    logic              fifo_push_s, fifo_pop_s, slot_free_s, wr_acc_s;

    px_fifo #(.DEPTH(FIFO_DEPTH), .W(PX_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (in_px_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Handshake, clipping and the pixel that would load the output slot.
    always_comb begin
        in_px_s.x     = Xn;
        in_px_s.y     = Yn;
        in_px_s.color = Px_Color;
        head_px_s     = pixel_t'(fifo_dout_s);
        sel_px_s      = fifo_empty_s ? in_px_s : head_px_s;
        accept_s      = px_valid & frame_ready_r;
        clip_s        = ({1'b0, Xn} >= X_LIM) || ({1'b0, Yn} >= Y_LIM);
        push_in_s     = accept_s & ~clip_s;
        wr_acc_s      = fb_we_r & ~fb_busy;
        slot_free_s   = ~fb_we_r | ~fb_busy;
    end

    // Next-state, output slot, drop counter and ready-flag computation.
    always_comb begin
        st_d          = st_r;
        clr_cnt_d     = clr_cnt_r;
        clr_color_d   = clr_color_r;
        clear_done_d  = 1'b0;
        fb_we_d       = fb_we_r;
        fb_addr_d     = fb_addr_r;
        fb_wdata_d    = fb_wdata_r;
        fifo_pop_s    = 1'b0;
        bypass_s      = 1'b0;

        case (st_r)
            RUN, DRAIN: begin
                if (slot_free_s) begin
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = px_addr(sel_px_s.x, sel_px_s.y);
                        fb_wdata_d = sel_px_s.color;
                    end else if (push_in_s) begin
                        bypass_s   = 1'b1;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = px_addr(sel_px_s.x, sel_px_s.y);
                        fb_wdata_d = sel_px_s.color;
                    end else begin
                        fb_we_d    = 1'b0;
                    end
                end else begin
                    fb_we_d = fb_we_r;
                end
                if (st_r == RUN) begin
                    if (clear_req) begin
                        st_d        = DRAIN;
                        clr_color_d = clear_color;
                    end else begin
                        st_d = RUN;
                    end
                end else if (fifo_empty_s && slot_free_s) begin
                    st_d       = CLEAR;
                    clr_cnt_d  = '0;
                    fb_we_d    = 1'b1;
                    fb_addr_d  = '0;
                    fb_wdata_d = clr_color_r;
                end else begin
                    st_d = DRAIN;
                end
            end
            CLEAR: begin
                if (wr_acc_s) begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        clear_done_d = 1'b1;
                        st_d         = RUN;
                        clr_cnt_d    = '0;
                        fb_we_d      = 1'b0;
                    end else begin
                        clr_cnt_d = clr_cnt_r + ADDR_W'(1);
                        fb_addr_d = clr_cnt_r + ADDR_W'(1);
                    end
                end else begin
                    clr_cnt_d = clr_cnt_r;
                end
            end
            default: begin
                st_d    = RUN;
                fb_we_d = 1'b0;
            end
        endcase

        if (accept_s && clip_s && (dropped_r != 16'hFFFF)) begin
            dropped_d = dropped_r + 16'd1;
        end else begin
            dropped_d = dropped_r;
        end

        fifo_push_s   = push_in_s & ~bypass_s & ~fifo_full_s;
        fifo_cnt_nx_s = fifo_count_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
        occ_nx_s      = {1'b0, fifo_cnt_nx_s} + (CW+1)'(fb_we_d);
        frame_ready_d = (st_d == RUN) && (occ_nx_s <= RDY_LIM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r          <= RUN;
            clr_cnt_r     <= '0;
            clr_color_r   <= 3'd0;
            frame_ready_r <= 1'b0;
            clear_done_r  <= 1'b0;
            dropped_r     <= 16'd0;
            fb_we_r       <= 1'b0;
            fb_addr_r     <= '0;
            fb_wdata_r    <= 3'd0;
        end else begin
            st_r          <= st_d;
            clr_cnt_r     <= clr_cnt_d;
            clr_color_r   <= clr_color_d;
            frame_ready_r <= frame_ready_d;
            clear_done_r  <= clear_done_d;
            dropped_r     <= dropped_d;
            fb_we_r       <= fb_we_d;
            fb_addr_r     <= fb_addr_d;
            fb_wdata_r    <= fb_wdata_d;
        end
    end

    assign frame_ready = frame_ready_r;
    assign clear_done  = clear_done_r;
    assign dropped     = dropped_r;
    assign fb_we       = fb_we_r;
    assign fb_addr     = fb_addr_r;
    assign fb_wdata    = fb_wdata_r;

endmodule

// File: tb/tb_px_writer.sv
// Directed bench: full-size instance for addressing/handshake, a 20x10
// instance for clear sequencing so clears stay short.
module tb_px_writer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance (640x480)
    logic [9:0]  b_x = 10'd0, b_y = 10'd0;
    logic [2:0]  b_c = 3'd0, b_clr_c = 3'd0;
    logic        b_valid = 1'b0, b_clear_req = 1'b0, b_busy = 1'b0;
    logic        b_ready, b_done, b_we;
    logic [18:0] b_addr;
    logic [2:0]  b_wdata;
    logic [15:0] b_dropped;

    // Small instance (20x10 -> 200 clear writes)
    logic [9:0]  s_x = 10'd0, s_y = 10'd0;
    logic [2:0]  s_c = 3'd0, s_clr_c = 3'd0;
    logic        s_valid = 1'b0, s_clear_req = 1'b0, s_busy = 1'b0;
    logic        s_ready, s_done, s_we;
    logic [7:0]  s_addr;
    logic [2:0]  s_wdata;
    logic [15:0] s_dropped;

    int n_chk = 0;
    int n_err = 0;

    px_writer u_big (
        .clk(clk), .rst(rst), .Xn(b_x), .Yn(b_y), .Px_Color(b_c), .px_valid(b_valid),
        .frame_ready(b_ready), .clear_req(b_clear_req), .clear_color(b_clr_c),
        .clear_done(b_done), .fb_addr(b_addr), .fb_wdata(b_wdata), .fb_we(b_we),
        .fb_busy(b_busy), .dropped(b_dropped)
    );

    px_writer #(.H_RES(20), .V_RES(10), .FIFO_DEPTH(8), .ADDR_W(8)) u_small (
        .clk(clk), .rst(rst), .Xn(s_x), .Yn(s_y), .Px_Color(s_c), .px_valid(s_valid),
        .frame_ready(s_ready), .clear_req(s_clear_req), .clear_color(s_clr_c),
        .clear_done(s_done), .fb_addr(s_addr), .fb_wdata(s_wdata), .fb_we(s_we),
        .fb_busy(s_busy), .dropped(s_dropped)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_a[3] = '{21, 42, 63};

    initial begin
        int wcnt, seq_err, done_cnt, stab_err, done_at, late_done;
        logic pend, hit;
        logic [7:0] paddr;
        logic [2:0] pdata;

        // Reset values
        #1;
        chk("rst_ready", b_ready, 0);
        chk("rst_we", b_we, 0);
        chk("rst_addr", b_addr, 0);
        chk("rst_wdata", b_wdata, 0);
        chk("rst_done", b_done, 0);
        chk("rst_dropped", b_dropped, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("ready_before_edge", b_ready, 0);
        tick();
        chk("ready_after_release", b_ready, 1);

        // Single pixel (10,20,5)
        b_x = 10'd10; b_y = 10'd20; b_c = 3'd5; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("px1_we", b_we, 1);
        chk("px1_addr", b_addr, 12810);
        chk("px1_wdata", b_wdata, 5);
        tick();
        chk("px1_idle_we", b_we, 0);

        // Seven pushes under fb_busy
        b_busy = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            b_x = 10'(3 * i); b_y = 10'(i); b_c = 3'(i); b_valid = 1'b1;
            tick();
            chk($sformatf("stall_ready_%0d", i), b_ready, (i < 7) ? 1 : 0);
        end
        // Protocol violation while not ready: must be discarded
        b_x = 10'd100; b_y = 10'd100; b_c = 3'd7; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("stall_hold_addr", b_addr, 643);
        b_busy = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("drain_we_%0d", i), b_we, 1);
            chk($sformatf("drain_addr_%0d", i), b_addr, 643 * i);
            chk($sformatf("drain_data_%0d", i), b_wdata, i);
            tick();
        end
        chk("drain_done_we", b_we, 0);
        chk("drain_ready", b_ready, 1);

        // Boundary and clipping
        b_x = 10'd639; b_y = 10'd479; b_c = 3'd4; b_valid = 1'b1;
        tick();
        chk("edge_addr", b_addr, 307199);
        chk("edge_data", b_wdata, 4);
        b_x = 10'd640; b_y = 10'd0; b_c = 3'd1;
        tick();
        chk("clip_x_dropped", b_dropped, 1);
        chk("clip_x_no_we", b_we, 0);
        b_x = 10'd0; b_y = 10'd480; b_c = 3'd2;
        tick();
        b_valid = 1'b0;
        chk("clip_y_dropped", b_dropped, 2);
        chk("clip_y_no_we", b_we, 0);

        // Sustained throughput with fb_busy low
        for (int i = 0; i < 5; i++) begin
            b_x = 10'(i + 1); b_y = 10'(i); b_c = 3'(i); b_valid = 1'b1;
            tick();
            chk($sformatf("thr_addr_%0d", i), b_addr, 641 * i + 1);
            chk($sformatf("thr_ready_%0d", i), b_ready, 1);
        end
        b_valid = 1'b0;
        tick();
        chk("thr_idle", b_we, 0);

        // Clear with three queued pixels, on the small instance
        s_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_x = 10'(i); s_y = 10'(i); s_c = 3'(i); s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        chk("clr_ready_before", s_ready, 1);
        s_clear_req = 1'b1; s_clr_c = 3'd2;
        tick();
        s_clear_req = 1'b0; s_clr_c = 3'd5;
        chk("clr_ready_drop", s_ready, 0);

        wcnt = 0; seq_err = 0; done_cnt = 0; stab_err = 0; done_at = -1; pend = 1'b0;
        paddr = 8'd0; pdata = 3'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done_cnt > 0 && cyc > done_at + 3) break;
            if (s_done) begin
                done_cnt++;
                done_at = cyc;
                chk("clr_ready_at_done", s_ready, 1);
            end
            if (pend && (s_we !== 1'b1 || s_addr !== paddr || s_wdata !== pdata)) stab_err++;
            s_busy = ((cyc % 7) == 3) || ((cyc % 7) == 4);
            s_clear_req = (wcnt == 53);
            if (s_we && !s_busy) begin
                if (wcnt < 3) begin
                    if (s_addr !== 8'(exp_a[wcnt]) || s_wdata !== 3'(wcnt + 1)) seq_err++;
                end else begin
                    if (s_addr !== 8'(wcnt - 3) || s_wdata !== 3'd2) seq_err++;
                end
                wcnt++;
                pend = 1'b0;
            end else begin
                pend = s_we;
            end
            paddr = s_addr;
            pdata = s_wdata;
            tick();
        end
        s_clear_req = 1'b0; s_busy = 1'b0;
        chk("clr_writes", wcnt - 3, 200);
        chk("clr_done_cnt", done_cnt, 1);
        chk("clr_seq_err", seq_err, 0);
        chk("clr_stall_stable", stab_err, 0);
        chk("clr_ready_after", s_ready, 1);
        chk("clr_we_after", s_we, 0);

        // Async reset in the middle of a clear
        s_clear_req = 1'b1; s_clr_c = 3'd6;
        tick();
        s_clear_req = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (s_we && s_addr == 8'd100) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_mid_hit", hit, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_we", s_we, 0);
        chk("rst_mid_addr", s_addr, 0);
        chk("rst_mid_wdata", s_wdata, 0);
        chk("rst_mid_done", s_done, 0);
        chk("rst_mid_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_mid_ready_pre", s_ready, 0);
        tick();
        chk("rst_mid_ready_post", s_ready, 1);
        s_x = 10'd5; s_y = 10'd0; s_c = 3'd3; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("post_rst_addr", s_addr, 5);
        chk("post_rst_data", s_wdata, 3);
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_done || s_we) late_done++;
            tick();
        end
        chk("post_rst_quiet", late_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
